// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller: tracks in-flight writers after ID,
// picks per-operand forwarding sources and raises load-use stall / branch flush.
module hazard_fwd_ctrl #(
    parameter int RW         = 5,
    parameter int NUM_SRC    = 2,
    parameter int FWD_DEPTH  = 2,
    parameter int LOAD_STAGE = 2,
    localparam int SW        = $clog2(FWD_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    id_valid_i,
    input  logic [NUM_SRC*RW-1:0]   id_src_i,
    input  logic [NUM_SRC-1:0]      id_src_used_i,
    input  logic                    id_wr_i,
    input  logic [RW-1:0]           id_dest_i,
    input  logic                    id_load_i,
    input  logic                    br_taken_i,
    input  logic                    halt_i,
    output logic                    stall_o,
    output logic                    bubble_o,
    output logic                    flush_o,
    output logic [NUM_SRC*SW-1:0]   fwd_sel_o,
    output logic [31:0]             stall_cnt_o,
    output logic [31:0]             flush_cnt_o
);

    logic [FWD_DEPTH:0]        vld_q, vld_d;
    logic [FWD_DEPTH:0]        wr_q, wr_d;
    logic [FWD_DEPTH:0]        ld_q, ld_d;
    logic [RW-1:0]             dst_q [FWD_DEPTH+1];
    logic [RW-1:0]             dst_d [FWD_DEPTH+1];
    logic [NUM_SRC*RW-1:0]     src_q, src_d;
    logic [NUM_SRC-1:0]        used_q, used_d;
    logic [31:0]               scnt_q, scnt_d;
    logic [31:0]               fcnt_q, fcnt_d;

    logic                      hz;
    logic                      flush;
    logic                      stall;
    logic [NUM_SRC*SW-1:0]     fwd;

    // Only stages before LOAD_STAGE-1 hold a load whose data is not yet forwardable.
    always_comb begin
        hz = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            for (int i = 0; i <= FWD_DEPTH; i++) begin
                if ((i + 2 <= LOAD_STAGE) && id_valid_i && id_src_used_i[k] &&
                    (id_src_i[k*RW +: RW] != '0) &&
                    vld_q[i] && wr_q[i] && ld_q[i] &&
                    (dst_q[i] == id_src_i[k*RW +: RW])) begin
                    hz = 1'b1;
                end
            end
        end
    end

    // Walk from the farthest stage inward so the nearest match overwrites.
    always_comb begin
        fwd = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            for (int i = FWD_DEPTH; i >= 1; i--) begin
                if (vld_q[0] && used_q[k] && vld_q[i] && wr_q[i] &&
                    (dst_q[i] != '0) &&
                    (dst_q[i] == src_q[k*RW +: RW])) begin
                    fwd[k*SW +: SW] = SW'(i);
                end
            end
        end
    end

    assign flush = br_taken_i & ~halt_i;
    assign stall = hz & ~flush & ~halt_i;

    always_comb begin
        vld_d  = vld_q;
        wr_d   = wr_q;
        ld_d   = ld_q;
        dst_d  = dst_q;
        src_d  = src_q;
        used_d = used_q;
        scnt_d = scnt_q;
        fcnt_d = fcnt_q;
        if (!halt_i) begin
            for (int i = 1; i <= FWD_DEPTH; i++) begin
                vld_d[i] = vld_q[i-1];
                wr_d[i]  = wr_q[i-1];
                ld_d[i]  = ld_q[i-1];
                dst_d[i] = dst_q[i-1];
            end
            if (flush) begin
                vld_d[0] = 1'b0;
                vld_d[1] = 1'b0;
            end else if (stall) begin
                vld_d[0] = 1'b0;
            end else begin
                vld_d[0] = id_valid_i;
                wr_d[0]  = id_wr_i;
                ld_d[0]  = id_load_i;
                dst_d[0] = id_dest_i;
                src_d    = id_src_i;
                used_d   = id_src_used_i;
            end
            if (stall && (scnt_q != 32'hFFFF_FFFF)) begin
                scnt_d = scnt_q + 32'd1;
            end
            if (flush && (fcnt_q != 32'hFFFF_FFFF)) begin
                fcnt_d = fcnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q  <= '0;
            wr_q   <= '0;
            ld_q   <= '0;
            src_q  <= '0;
            used_q <= '0;
            scnt_q <= '0;
            fcnt_q <= '0;
            for (int i = 0; i <= FWD_DEPTH; i++) begin
                dst_q[i] <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            wr_q   <= wr_d;
            ld_q   <= ld_d;
            dst_q  <= dst_d;
            src_q  <= src_d;
            used_q <= used_d;
            scnt_q <= scnt_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign stall_o     = rst_n & stall;
    assign bubble_o    = rst_n & stall;
    assign flush_o     = rst_n & flush;
    assign fwd_sel_o   = rst_n ? fwd : '0;
    assign stall_cnt_o = rst_n ? scnt_q : '0;
    assign flush_cnt_o = rst_n ? fcnt_q : '0;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: default instance plus a deeper
// LOAD_STAGE=3 / FWD_DEPTH=3 instance sharing the same stimulus.
module tb_hazard_fwd_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [9:0]  id_src = '0;
    logic [1:0]  id_used = '0;
    logic        id_wr = 1'b0;
    logic [4:0]  id_dest = '0;
    logic        id_load = 1'b0;
    logic        br = 1'b0;
    logic        halt = 1'b0;

    logic        stall, bubble, flush;
    logic [3:0]  fwd;
    logic [31:0] scnt, fcnt;

    logic        stall3, bubble3, flush3;
    logic [3:0]  fwd3;
    logic [31:0] scnt3, fcnt3;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    hazard_fwd_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid_i(id_valid), .id_src_i(id_src), .id_src_used_i(id_used),
        .id_wr_i(id_wr), .id_dest_i(id_dest), .id_load_i(id_load),
        .br_taken_i(br), .halt_i(halt),
        .stall_o(stall), .bubble_o(bubble), .flush_o(flush),
        .fwd_sel_o(fwd), .stall_cnt_o(scnt), .flush_cnt_o(fcnt)
    );

    hazard_fwd_ctrl #(.FWD_DEPTH(3), .LOAD_STAGE(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .id_valid_i(id_valid), .id_src_i(id_src), .id_src_used_i(id_used),
        .id_wr_i(id_wr), .id_dest_i(id_dest), .id_load_i(id_load),
        .br_taken_i(br), .halt_i(halt),
        .stall_o(stall3), .bubble_o(bubble3), .flush_o(flush3),
        .fwd_sel_o(fwd3), .stall_cnt_o(scnt3), .flush_cnt_o(fcnt3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                          input logic [1:0] u, input logic w, input logic [4:0] d,
                          input logic ld);
        id_valid = v;
        id_src   = {s1, s0};
        id_used  = u;
        id_wr    = w;
        id_dest  = d;
        id_load  = ld;
    endtask

    task automatic nop();
        set_id(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        br    = 1'b0;
        halt  = 1'b0;
        nop();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        br = 1'b1;
        set_id(1'b1, 5'd3, 5'd3, 2'b11, 1'b1, 5'd3, 1'b1);
        tick();
        #2;
        total++;
        if ({stall, bubble, flush} !== 3'b000) begin
            bad++;
            $display("FAIL reset_ctl got=%b exp=000", {stall, bubble, flush});
        end
        total++;
        if (fwd !== 4'h0) begin
            bad++;
            $display("FAIL reset_fwd got=%h exp=0", fwd);
        end
        total++;
        if ((scnt !== 32'd0) || (fcnt !== 32'd0)) begin
            bad++;
            $display("FAIL reset_cnt got=%0d/%0d exp=0/0", scnt, fcnt);
        end
        br = 1'b0;
        nop();
        rst_n = 1'b1;
    endtask

    task automatic test_fwd_alu();
        do_reset();
        set_id(1'b1, 5'd1, 5'd2, 2'b11, 1'b1, 5'd3, 1'b0);
        tick();
        set_id(1'b1, 5'd3, 5'd5, 2'b11, 1'b1, 5'd4, 1'b0);
        #2;
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL alu_nostall got=%b exp=0", stall);
        end
        tick();
        nop();
        #2;
        total++;
        if (fwd !== 4'b0001) begin
            bad++;
            $display("FAIL alu_fwd got=%b exp=0001", fwd);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1'b1, 5'd1, 5'd0, 2'b01, 1'b1, 5'd3, 1'b1);
        tick();
        set_id(1'b1, 5'd3, 5'd3, 2'b11, 1'b1, 5'd4, 1'b0);
        #2;
        total++;
        if ({stall, bubble} !== 2'b11) begin
            bad++;
            $display("FAIL lu_stall got=%b exp=11", {stall, bubble});
        end
        tick();
        #2;
        total++;
        if ((stall !== 1'b0) || (scnt !== 32'd1)) begin
            bad++;
            $display("FAIL lu_release got=%b/%0d exp=0/1", stall, scnt);
        end
        tick();
        nop();
        #2;
        total++;
        if (fwd !== 4'b1010) begin
            bad++;
            $display("FAIL lu_fwd got=%b exp=1010", fwd);
        end
    endtask

    task automatic test_load_stage3();
        do_reset();
        set_id(1'b1, 5'd1, 5'd0, 2'b01, 1'b1, 5'd7, 1'b1);
        tick();
        set_id(1'b1, 5'd7, 5'd0, 2'b11, 1'b1, 5'd8, 1'b0);
        #2;
        total++;
        if ({stall3, bubble3} !== 2'b11) begin
            bad++;
            $display("FAIL ls3_stall1 got=%b exp=11", {stall3, bubble3});
        end
        tick();
        #2;
        total++;
        if (stall3 !== 1'b1) begin
            bad++;
            $display("FAIL ls3_stall2 got=%b exp=1", stall3);
        end
        tick();
        #2;
        total++;
        if ((stall3 !== 1'b0) || (scnt3 !== 32'd2)) begin
            bad++;
            $display("FAIL ls3_release got=%b/%0d exp=0/2", stall3, scnt3);
        end
        tick();
        nop();
        #2;
        total++;
        if (fwd3 !== 4'b0011) begin
            bad++;
            $display("FAIL ls3_fwd got=%b exp=0011", fwd3);
        end
    endtask

    task automatic test_priority();
        do_reset();
        set_id(1'b1, 5'd1, 5'd2, 2'b11, 1'b1, 5'd3, 1'b0);
        tick();
        set_id(1'b1, 5'd4, 5'd5, 2'b11, 1'b1, 5'd3, 1'b0);
        tick();
        set_id(1'b1, 5'd3, 5'd3, 2'b01, 1'b1, 5'd6, 1'b0);
        tick();
        nop();
        #2;
        total++;
        if (fwd !== 4'b0001) begin
            bad++;
            $display("FAIL near_wins got=%b exp=0001", fwd);
        end
        do_reset();
        set_id(1'b1, 5'd1, 5'd2, 2'b11, 1'b1, 5'd0, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 2'b11, 1'b1, 5'd6, 1'b0);
        tick();
        nop();
        #2;
        total++;
        if (fwd !== 4'b0000) begin
            bad++;
            $display("FAIL r0_nofwd got=%b exp=0000", fwd);
        end
        do_reset();
        set_id(1'b1, 5'd1, 5'd0, 2'b01, 1'b1, 5'd0, 1'b1);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 2'b11, 1'b1, 5'd6, 1'b0);
        #2;
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL r0_nostall got=%b exp=0", stall);
        end
        do_reset();
        set_id(1'b1, 5'd1, 5'd2, 2'b11, 1'b0, 5'd5, 1'b0);
        tick();
        set_id(1'b1, 5'd5, 5'd5, 2'b11, 1'b1, 5'd6, 1'b0);
        tick();
        nop();
        #2;
        total++;
        if (fwd !== 4'b0000) begin
            bad++;
            $display("FAIL nowr_nofwd got=%b exp=0000", fwd);
        end
    endtask

    task automatic test_flush_hz();
        do_reset();
        set_id(1'b1, 5'd1, 5'd0, 2'b01, 1'b1, 5'd3, 1'b1);
        tick();
        set_id(1'b1, 5'd3, 5'd3, 2'b11, 1'b1, 5'd4, 1'b0);
        br = 1'b1;
        #2;
        total++;
        if ({flush, stall, bubble} !== 3'b100) begin
            bad++;
            $display("FAIL fl_prio got=%b exp=100", {flush, stall, bubble});
        end
        tick();
        br = 1'b0;
        #2;
        total++;
        if ((stall !== 1'b0) || (fcnt !== 32'd1) || (scnt !== 32'd0)) begin
            bad++;
            $display("FAIL fl_after got=%b/%0d/%0d exp=0/1/0", stall, fcnt, scnt);
        end
        tick();
        nop();
        #2;
        total++;
        if (fwd !== 4'b0000) begin
            bad++;
            $display("FAIL fl_killed got=%b exp=0000", fwd);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_id(1'b1, 5'd1, 5'd0, 2'b01, 1'b1, 5'd3, 1'b1);
        tick();
        set_id(1'b1, 5'd3, 5'd0, 2'b01, 1'b1, 5'd4, 1'b1);
        tick();
        tick();
        set_id(1'b1, 5'd4, 5'd0, 2'b01, 1'b1, 5'd5, 1'b0);
        #2;
        total++;
        if ((stall !== 1'b1) || (fwd !== 4'b0010) || (scnt !== 32'd1)) begin
            bad++;
            $display("FAIL pre_rst got=%b/%b/%0d exp=1/0010/1", stall, fwd, scnt);
        end
        rst_n = 1'b0;
        br = 1'b1;
        #1;
        total++;
        if ({stall, bubble, flush, fwd} !== 7'd0 || scnt !== 32'd0 || fcnt !== 32'd0) begin
            bad++;
            $display("FAIL rst_force got=%b%b%b/%b/%0d/%0d exp=000/0000/0/0",
                     stall, bubble, flush, fwd, scnt, fcnt);
        end
        tick();
        rst_n = 1'b1;
        br = 1'b0;
        #2;
        total++;
        if ((stall !== 1'b0) || (scnt !== 32'd0)) begin
            bad++;
            $display("FAIL rst_clear got=%b/%0d exp=0/0", stall, scnt);
        end
        tick();
        nop();
        #2;
        total++;
        if (fwd !== 4'b0000) begin
            bad++;
            $display("FAIL rst_trk got=%b exp=0000", fwd);
        end
    endtask

    task automatic test_halt();
        do_reset();
        set_id(1'b1, 5'd1, 5'd0, 2'b01, 1'b1, 5'd3, 1'b1);
        tick();
        set_id(1'b1, 5'd3, 5'd3, 2'b11, 1'b1, 5'd4, 1'b0);
        tick();
        tick();
        nop();
        halt = 1'b1;
        br = 1'b1;
        #2;
        total++;
        if ((fwd !== 4'b1010) || (flush !== 1'b0)) begin
            bad++;
            $display("FAIL halt_in got=%b/%b exp=1010/0", fwd, flush);
        end
        tick();
        tick();
        #2;
        total++;
        if ((fwd !== 4'b1010) || (scnt !== 32'd1) || (fcnt !== 32'd0)) begin
            bad++;
            $display("FAIL halt_hold got=%b/%0d/%0d exp=1010/1/0", fwd, scnt, fcnt);
        end
        halt = 1'b0;
        br = 1'b0;
        tick();
        #2;
        total++;
        if ((fwd !== 4'b0000) || (scnt !== 32'd1)) begin
            bad++;
            $display("FAIL halt_resume got=%b/%0d exp=0000/1", fwd, scnt);
        end
    endtask

    initial begin
        test_reset();
        test_fwd_alu();
        test_load_use();
        test_load_stage3();
        test_priority();
        test_flush_hz();
        test_reset_mid_stall();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
